// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared RV32I(+M) decode types and encodings for the decode/control stage.
//   alu_op_t      : ALU operation select (ALU_ADD is the all-zero encoding)
//   md_op_t       : MUL/DIV operation, encoded exactly as the R-type funct3
//   ctrl_bundle_t : packed execute-stage control bundle
//   OP_*          : major opcodes, F7_* funct7 classes, INSTR_* exact words
//   SRC_A_*/WB_*  : operand-A mux and write-back mux encodings
// -----------------------------------------------------------------------------
package riscv_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_op_t;

   typedef enum logic [2:0] {
      MD_MUL    = 3'b000,
      MD_MULH   = 3'b001,
      MD_MULHSU = 3'b010,
      MD_MULHU  = 3'b011,
      MD_DIV    = 3'b100,
      MD_DIVU   = 3'b101,
      MD_REM    = 3'b110,
      MD_REMU   = 3'b111
   } md_op_t;

   typedef struct packed {
      logic       reg_write;
      alu_op_t    alu_ctrl;
      logic [1:0] alu_src_a;
      logic       alu_src;
      logic       mem_write;
      logic [1:0] mem_to_reg;
      logic       branch;
      logic       jump;
      logic       jalr;
      md_op_t     md_op;
      logic       md_en;
      logic       illegal;
      logic       ecall;
      logic       ebreak;
   } ctrl_bundle_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

   localparam logic [1:0] SRC_A_RS1  = 2'b00;
   localparam logic [1:0] SRC_A_PC   = 2'b01;
   localparam logic [1:0] SRC_A_ZERO = 2'b10;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;

   // ALU op for the "plain" funct3 of R-type and I-ALU; funct3=000/101 with
   // funct7=0100000 (SUB/SRA) are resolved by the caller.
   function automatic alu_op_t alu_from_f3(input logic [2:0] f3);
      case (f3)
         3'b000:  return ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/decode_ctrl_comb.sv
// -----------------------------------------------------------------------------
// decode_ctrl_comb
// Purely combinational RV32I(+M) instruction -> ctrl_bundle_t decode with
// illegal / ECALL / EBREAK detection.
//   i_instr : 32-bit instruction word
//   o_ctrl  : decoded control bundle
// An illegal encoding yields an all-zero bundle with only illegal=1, so no
// architectural side effect can leak from a bad instruction.
// -----------------------------------------------------------------------------
module decode_ctrl_comb
   import riscv_pkg::*;
#(
   parameter int ENABLE_M = 1
) (
   input  logic [31:0]  i_instr,
   output ctrl_bundle_t o_ctrl
);

   logic [6:0]   w_opcode;
   logic [2:0]   w_f3;
   logic [6:0]   w_f7;
   ctrl_bundle_t w_ctrl;
   logic         w_bad;

   assign w_opcode = i_instr[6:0];
   assign w_f3     = i_instr[14:12];
   assign w_f7     = i_instr[31:25];

   always_comb begin
      // NOTE: every variable gets a default before any branch so that no path
      // leaves it unassigned; otherwise synthesis would infer a latch.
      w_ctrl = '0;
      w_bad  = 1'b0;

      if (i_instr[1:0] != 2'b11) begin
         w_bad = 1'b1;
      end else begin
         case (w_opcode)
            OP_R: begin
               w_ctrl.reg_write = 1'b1;
               if (w_f7 == F7_BASE) begin
                  w_ctrl.alu_ctrl = alu_from_f3(w_f3);
               end else if (w_f7 == F7_ALT) begin
                  if (w_f3 == 3'b000)      w_ctrl.alu_ctrl = ALU_SUB;
                  else if (w_f3 == 3'b101) w_ctrl.alu_ctrl = ALU_SRA;
                  else                     w_bad = 1'b1;
               end else if ((w_f7 == F7_MULDIV) && (ENABLE_M != 0)) begin
                  // Multiply/divide: ALU stays at ADD, the MD unit does the work.
                  w_ctrl.md_en = 1'b1;
                  w_ctrl.md_op = md_op_t'(w_f3);
               end else begin
                  w_bad = 1'b1;
               end
            end

            OP_IMM: begin
               w_ctrl.reg_write = 1'b1;
               w_ctrl.alu_src   = 1'b1;
               w_ctrl.alu_ctrl  = alu_from_f3(w_f3);
               if ((w_f3 == 3'b001) && (w_f7 != F7_BASE)) begin
                  w_bad = 1'b1;
               end else if (w_f3 == 3'b101) begin
                  if (w_f7 == F7_ALT)       w_ctrl.alu_ctrl = ALU_SRA;
                  else if (w_f7 != F7_BASE) w_bad = 1'b1;
               end
            end

            OP_LOAD: begin
               w_ctrl.reg_write  = 1'b1;
               w_ctrl.alu_src    = 1'b1;
               w_ctrl.mem_to_reg = WB_MEM;
               w_bad = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
            end

            OP_STORE: begin
               w_ctrl.mem_write = 1'b1;
               w_ctrl.alu_src   = 1'b1;
               w_bad = (w_f3 >= 3'b011);
            end

            OP_BRANCH: begin
               w_ctrl.branch = 1'b1;
               // BEQ/BNE compare by subtraction, BLT/BGE signed, BLTU/BGEU unsigned.
               case (w_f3[2:1])
                  2'b00:   w_ctrl.alu_ctrl = ALU_SUB;
                  2'b10:   w_ctrl.alu_ctrl = ALU_SLT;
                  2'b11:   w_ctrl.alu_ctrl = ALU_SLTU;
                  default: w_bad = 1'b1;
               endcase
            end

            OP_JAL: begin
               w_ctrl.reg_write  = 1'b1;
               w_ctrl.jump       = 1'b1;
               w_ctrl.alu_src_a  = SRC_A_PC;
               w_ctrl.alu_src    = 1'b1;
               w_ctrl.mem_to_reg = WB_PC4;
            end

            OP_JALR: begin
               w_ctrl.reg_write  = 1'b1;
               w_ctrl.jalr       = 1'b1;
               w_ctrl.alu_src    = 1'b1;
               w_ctrl.mem_to_reg = WB_PC4;
               w_bad = (w_f3 != 3'b000);
            end

            OP_LUI: begin
               w_ctrl.reg_write = 1'b1;
               w_ctrl.alu_src_a = SRC_A_ZERO;
               w_ctrl.alu_src   = 1'b1;
            end

            OP_AUIPC: begin
               w_ctrl.reg_write = 1'b1;
               w_ctrl.alu_src_a = SRC_A_PC;
               w_ctrl.alu_src   = 1'b1;
            end

            OP_SYSTEM: begin
               // Only the two exact encodings are supported; CSR ops etc. trap.
               if (i_instr == INSTR_ECALL)       w_ctrl.ecall  = 1'b1;
               else if (i_instr == INSTR_EBREAK) w_ctrl.ebreak = 1'b1;
               else                              w_bad = 1'b1;
            end

            OP_FENCE: ;  // single-hart in-order core: FENCE is a NOP

            default: w_bad = 1'b1;
         endcase
      end

      if (w_bad) begin
         w_ctrl         = '0;
         w_ctrl.illegal = 1'b1;
      end
   end

   assign o_ctrl = w_ctrl;

endmodule

// File: rtl/decode_ctrl_stage.sv
// -----------------------------------------------------------------------------
// decode_ctrl_stage
// Registered decode stage (ID/EX register) between fetch and execute.
//   clk, rst_n        : clock, asynchronous active-low reset
//   flush             : drop held and incoming instruction (redirect)
//   in_valid/in_ready : fetch-side handshake; in_instr/in_pc payload
//   out_valid/out_ready: execute-side handshake
//   out_pc/out_instr  : registered PC and instruction word
//   out_ctrl          : registered control bundle
//   busy              : multi-cycle MUL/DIV occupancy in progress
// An M-op with latency LAT keeps the stage for LAT-1 cycles in MD_WAIT after
// the accepting edge, so out_valid rises LAT cycles after acceptance.
// -----------------------------------------------------------------------------
module decode_ctrl_stage
   import riscv_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int ENABLE_M    = 1,
   parameter int MUL_LATENCY = 2,
   parameter int DIV_LATENCY = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [31:0]     out_instr,
   output ctrl_bundle_t    out_ctrl,
   output logic            busy
);

   localparam int LAT_MAX = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
   localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX + 1) : 1;
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LATENCY - 1);

   typedef enum logic [1:0] {
      S_EMPTY   = 2'd0,
      S_FULL    = 2'd1,
      S_MD_WAIT = 2'd2
   } state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_count;
   logic              r_out_valid;
   logic              r_busy;
   ctrl_bundle_t      r_ctrl;
   logic [XLEN-1:0]   r_pc;
   logic [31:0]       r_instr;

   ctrl_bundle_t      w_ctrl;
   logic              w_accept;
   logic [CNT_W-1:0]  w_lat_load;
   logic              w_md_wait;

   decode_ctrl_comb #(
      .ENABLE_M (ENABLE_M)
   ) u_decode (
      .i_instr (in_instr),
      .o_ctrl  (w_ctrl)
   );

   // Ready is a function of held state only, never of flush, to keep the
   // fetch-side timing path short.
   assign in_ready = (r_state == S_EMPTY) || ((r_state == S_FULL) && out_ready);
   assign w_accept = in_valid && in_ready && !flush;

   // md_op[2] separates the divide group (funct3 1xx) from the multiply group.
   assign w_lat_load = w_ctrl.md_op[2] ? DIV_LOAD : MUL_LOAD;
   assign w_md_wait  = w_ctrl.md_en && (w_lat_load != '0);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_EMPTY;
         r_count     <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_ctrl      <= '0;
         r_pc        <= '0;
         r_instr     <= '0;
      end else if (flush) begin
         r_state     <= S_EMPTY;
         r_count     <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_ctrl      <= '0;
      end else if (w_accept) begin
         r_ctrl  <= w_ctrl;
         r_pc    <= in_pc;
         r_instr <= in_instr;
         if (w_md_wait) begin
            r_state     <= S_MD_WAIT;
            r_count     <= w_lat_load;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b1;
         end else begin
            r_state     <= S_FULL;
            r_count     <= '0;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
         end
      end else begin
         case (r_state)
            S_FULL: begin
               if (out_ready) begin
                  r_state     <= S_EMPTY;
                  r_out_valid <= 1'b0;
               end
            end
            S_MD_WAIT: begin
               // Leave when the decrement would reach zero: LAT-1 wait cycles.
               if (r_count <= CNT_W'(1)) begin
                  r_count     <= '0;
                  r_state     <= S_FULL;
                  r_out_valid <= 1'b1;
                  r_busy      <= 1'b0;
               end else begin
                  r_count <= r_count - CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign out_ctrl  = r_ctrl;
   assign out_pc    = r_pc;
   assign out_instr = r_instr;

endmodule

// File: doc/decode_ctrl_stage.md
Name: decode_ctrl_stage

Overview:
- Registered successor to the combinational control decoder. It decodes RV32I plus an optional M extension into the execute-stage control bundle.
- It holds the result in an ID/EX output register with a valid/ready handshake and sequences multi-cycle MUL/DIV occupancy with a countdown.
- It flags illegal instructions, ECALL and EBREAK instead of silently treating them as NOPs.
- It sits between fetch and execute in the pipeline.

Parameters:
- XLEN, 32, datapath and PC width.
- ENABLE_M, 1, decode funct7=0000001 R-type as MUL/DIV; when 0 these are illegal.
- MUL_LATENCY, 2, cycles an M-multiply (funct3 000-011) occupies the stage before out_valid; must be >= 1.
- DIV_LATENCY, 32, cycles an M-divide (funct3 100-111) occupies the stage; must be >= 1.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- flush, input, 1, kill the held or incoming instruction (branch redirect).
- in_valid, input, 1, fetch presents an instruction.
- in_ready, output, 1, stage can accept this cycle.
- in_instr, input, 32, instruction word.
- in_pc, input, XLEN, instruction PC.
- out_valid, output, 1, control bundle valid.
- out_ready, input, 1, execute consumes the bundle.
- out_pc, output, XLEN, registered PC.
- out_instr, output, 32, registered instruction word.
- out_ctrl, output, ctrl_bundle_t, packed bundle: reg_write, alu_ctrl (alu_op_t), alu_src_a[1:0], alu_src, mem_write, mem_to_reg[1:0], branch, jump, jalr, md_op (md_op_t), md_en, illegal, ecall, ebreak.
- busy, output, 1, high while in MD_WAIT.

Behaviour:
- Reset (async, rst_n=0): state=EMPTY, out_valid=0, busy=0, out_ctrl=all zero (alu_ctrl=ALU_ADD, md_op=MD_MUL), out_pc=0, out_instr=0, counter=0.
- States:
  - EMPTY: nothing held.
  - FULL: bundle held, out_valid=1.
  - MD_WAIT: M-op held, counting down, out_valid=0.
- in_ready = (state==EMPTY) | (state==FULL & out_ready). It is 0 in MD_WAIT. in_ready does not depend on flush.
- Accept: in_valid & in_ready & !flush. The decoded bundle, in_pc and in_instr register on that edge; latency is 1 cycle.
- After accept:
  - md_en=1 goes to MD_WAIT with counter=LAT-1, where LAT is MUL_LATENCY or DIV_LATENCY.
  - If LAT==1, go directly to FULL.
  - Otherwise go to FULL.
- MD_WAIT: counter decrements each cycle. At counter==0 the next state is FULL.
- FULL with out_ready & no accept goes to EMPTY. FULL with out_ready & accept is a back-to-back transfer, with no bubble.
- flush (highest priority): next state is EMPTY and out_valid drops next cycle. An instruction presented in the same cycle is dropped. The counter resets to 0. out_ctrl is zeroed.
- Decode rules:
  - Control values for legal opcodes (R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC) are unchanged from the current ALU/mux encoding.
  - mem_to_reg: 00=ALU, 01=mem, 10=PC+4. alu_src_a: 00=rs1, 01=PC, 10=zero.
  - SYSTEM: instr==0x00000073 sets ecall; 0x00100073 sets ebreak. Any other SYSTEM encoding is illegal. FENCE is a NOP.
- Illegal conditions:
  - unknown opcode;
  - R-type funct7 not in {0000000, 0100000, 0000001&ENABLE_M};
  - funct7=0100000 with funct3 not in {000, 101};
  - SLLI funct7!=0;
  - SRLI/SRAI funct7 not in {0000000, 0100000};
  - branch funct3 010/011;
  - load funct3 011/110/111;
  - store funct3 >= 011;
  - JALR funct3!=000;
  - in_instr[1:0]!=11.
- Any illegal, ecall or ebreak forces reg_write=0, mem_write=0, branch=0, jump=0, jalr=0, md_en=0.
- M-ext: reg_write=1, alu_src=0, mem_to_reg=00, md_en=1, md_op=funct3. alu_ctrl stays ALU_ADD.
- Output stability: out_ctrl, out_pc and out_instr hold while out_valid & !out_ready.
- Reset mid-MD_WAIT returns to EMPTY immediately.

Decomposition:
- The shared package riscv_pkg gains:
  - md_op_t: MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU, encoded as funct3.
  - ctrl_bundle_t: packed struct.
  - F7_BASE/F7_ALT/F7_MULDIV constants.
  - INSTR_ECALL/INSTR_EBREAK constants.
- One sub-module, decode_ctrl_comb, holds the purely combinational instr-to-ctrl_bundle_t decode including illegal detection.
- decode_ctrl_stage holds the FSM, counter and registers.

Test Plan:
- Reset then add x3,x1,x2 (0x002081B3) with out_ready=1 → out_valid next cycle, reg_write=1, alu_ctrl=ALU_ADD, mem_to_reg=00, illegal=0; in_ready stays 1.
- Stream of 4 addi with out_ready=1 → 4 consecutive out_valid cycles, no bubbles, out_pc increments by 4.
- div x5,x6,x7 (0x027342B3), DIV_LATENCY=32 → busy=1 and in_ready=0 for 31 cycles, then out_valid=1, md_op=MD_DIV, md_en=1; with ENABLE_M=0 → illegal=1, reg_write=0.
- Backpressure: out_ready=0 for 5 cycles while FULL → in_ready=0, out_ctrl/out_pc unchanged; out_ready=1 → transfer, and a new instruction is accepted in the same cycle.
- flush asserted during MD_WAIT at counter=10, concurrent with in_valid → next cycle EMPTY, out_valid=0, busy=0, incoming instruction dropped.
- 0x00000073 → ecall=1; 0x00100073 → ebreak=1; 0x0000A003 (load funct3 010 legal) → mem_to_reg=01; 0x0000B003 → illegal=1; 0xFFFFFFFF → illegal=1; all with reg_write=0 except the legal load.
